sync_fifo_fwft: RTL
===================

// Module: sync_fifo_fwft
// PURPOSE
//  Single-clock parametrised FIFO for buffering bus-side traffic (e.g. APB write/read data queues).
//  All DEPTH entries are usable, with a selectable read mode: standard registered read or first-word-fall-through.
//  Provides programmable almost-full/almost-empty thresholds, an exact occupancy count and sticky overflow/underflow flags.
// PARAMETERS
//  DATA_WIDTH     8                  word width in bits
//  ADDR_WIDTH     4                  log2 of depth
//  DEPTH          1<<ADDR_WIDTH      number of entries; must equal 1<<ADDR_WIDTH
//  FWFT           0                  0 = standard registered read, 1 = first-word-fall-through
//  AFULL_THRESH   DEPTH-1            almost_full when count >= this; legal range 1..DEPTH
//  AEMPTY_THRESH  1                  almost_empty when count <= this; legal range 0..DEPTH-1
// PORTS
//  clk           in   1             single clock; all state on rising edge
//  rst           in   1             asynchronous reset, active-high
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write data
//  rd_en         in   1             read request / head-word acknowledge (FWFT)
//  rd_data       out  DATA_WIDTH    read data
//  rd_valid      out  1             rd_data holds a valid word
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AFULL_THRESH
//  almost_empty  out  1             count <= AEMPTY_THRESH
//  count         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
//  clr_err       in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//  - wptr/rptr are ADDR_WIDTH+1 bits; memory index is ptr[ADDR_WIDTH-1:0].
//    count = wptr - rptr (modulo 2^(ADDR_WIDTH+1)); empty = (wptr==rptr);
//    full = MSBs differ and low bits are equal.
//  - Write is accepted iff wr_en && !full: mem[wptr] <= wr_data, wptr++.
//  - Read is accepted iff rd_en && !empty: rptr++.
//  - full/empty are evaluated from the pre-edge state:
//    at full, wr_en+rd_en -> only the read is accepted (count-1);
//    at empty, wr_en+rd_en -> only the write is accepted (count+1).
//  - Otherwise simultaneous read+write leaves count unchanged. Pointers wrap naturally.
//  - FWFT=0: on an accepted read, rd_data <= mem[rptr] and rd_valid <= 1 next cycle (latency 1).
//    rd_valid <= 0 in any cycle without an accepted read; rd_data holds its last value.
//  - FWFT=1: rd_data = mem[rptr] and rd_valid = !empty, both combinational from registers.
//    A word written at edge N is visible after edge N. rd_en pops the head.
//  - All flags and count are derived combinationally from registered pointers only;
//    there is no combinational path from wr_en/rd_en to any output.
//  - overflow is set on wr_en && full; underflow is set on rd_en && empty.
//    clr_err clears both; if set and clear occur in the same cycle, set wins.
//    Rejected requests never move a pointer.
//  - Reset (asynchronous, any time): wptr=rptr=0, rd_data=0, rd_valid=0, overflow=underflow=0.
//    Outputs then read empty=1, full=0, count=0, almost_empty=1, almost_full=0.
//    Memory contents are not reset; in-flight data is discarded.
//  - Out-of-range thresholds or DEPTH != 1<<ADDR_WIDTH: elaboration-time error.
// TESTING
//  Use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
//  1 Reset -> empty=1, full=0, count=0, rd_valid=0, rd_data=0x00, almost_empty=1, overflow=underflow=0.
//  2 Write A0,A1,A2,A3 -> almost_full=1 at count=3; full=1 at count=4.
//    A 5th write (0xFF) is dropped and overflow=1.
//    FWFT=0 reads return A0..A3, each with rd_valid one cycle after rd_en; empty=1 at the end.
//  3 At count=4, wr_en+rd_en with 0xB0 -> A0 read, 0xB0 rejected, count=3, overflow=1.
//    At count=0, wr_en+rd_en with 0xC0 -> write only, count=1, underflow=1.
//    clr_err -> both flags 0.
//  4 Stream 10 words (0x10..0x19) at steady count=2 with simultaneous rd/wr.
//    -> count stays 2 and in-order output is preserved across pointer wrap (wptr passes 7->0).
//  5 FWFT=1: write 0x5A at edge N -> rd_valid=1, rd_data=0x5A after N.
//    rd_en at N+1 -> empty=1, rd_valid=0.
//  6 Assert rst mid-stream at count=3 -> count=0, empty=1, rd_valid=0 immediately (before the next edge).
//    A subsequent write/read returns the new data only.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with all DEPTH entries usable, selectable registered or first-word-fall-through
// read, programmable almost-full/almost-empty levels, exact occupancy and sticky error flags.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 1 << ADDR_WIDTH,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must equal 1<<ADDR_WIDTH");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_fwft: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_fwft: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                        (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // NOTE: storage has no reset so it maps onto plain RAM; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      // A new error in the same cycle as clr_err must not be lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign rd_data  = mem[rptr[ADDR_WIDTH-1:0]];
    assign rd_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem[rptr[ADDR_WIDTH-1:0]];
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
